trng_health_ctrl: RTL and testbench

Sequencer between the entropy-source sampler and the health_test instance.
- Gates health_test enable and runs a startup qualification window.
- Forwards only qualified samples to a one-entry valid/ready output register.
- Suspends output on health alarms until a clean recovery run completes, and latches total failure until software clears it.

---
 rtl/trng_health_ctrl.sv | 147 ++++++++++++++
 tb/tb_trng_health_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_health_ctrl.sv
// Sequencer between the entropy sampler and health_test: startup/recovery qualification,
// one-entry valid/ready output buffer, failure latch. Define TRNG_CTRL_STATS_EN to build alarm/drop counters.
module trng_health_ctrl #(
  parameter int NBITS           = 32,
  parameter int STARTUP_SAMPLES = 1024,
  parameter int RECOVER_SAMPLES = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear_fail,
  input  logic [NBITS-1:0] samples,
  input  logic             sample_valid,
  output logic [NBITS-1:0] ht_samples,
  output logic             ht_enable,
  input  logic             ht_error,
  input  logic             ht_total_failure,
  output logic [NBITS-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       state,
  output logic             fail,
  output logic [CNT_W-1:0] alarm_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STARTUP = 3'd1,
    ST_RUN     = 3'd2,
    ST_RECOVER = 3'd3,
    ST_FAILED  = 3'd4
  } state_e;

  localparam int QMAX = (STARTUP_SAMPLES > RECOVER_SAMPLES) ? STARTUP_SAMPLES : RECOVER_SAMPLES;
  localparam int QW   = (QMAX > 1) ? $clog2(QMAX) : 1;
  localparam logic [QW-1:0] START_LAST = QW'(STARTUP_SAMPLES - 1);
  localparam logic [QW-1:0] REC_LAST   = QW'(RECOVER_SAMPLES - 1);

  state_e           state_q;
  logic [QW-1:0]    qual_q;
  logic             out_valid_q;
  logic [NBITS-1:0] out_data_q;

  logic active, clean, bad, abort, xfer, can_load;

  assign active   = (state_q == ST_STARTUP) || (state_q == ST_RUN) || (state_q == ST_RECOVER);
  assign clean    = sample_valid && !ht_error;
  assign bad      = sample_valid && ht_error;
  assign abort    = active && (ht_total_failure || stop);
  assign xfer     = out_valid_q && out_ready;
  assign can_load = !out_valid_q || out_ready;

  // health_test has no reset of its own, so it only ever sees samples while we are qualifying or running
  assign ht_samples = samples;
  assign ht_enable  = sample_valid && active;

  assign state     = state_q;
  assign fail      = (state_q == ST_FAILED);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      qual_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (abort) begin
      state_q     <= ht_total_failure ? ST_FAILED : ST_IDLE;
      qual_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (xfer) out_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_STARTUP;
            qual_q  <= '0;
          end
        end
        ST_STARTUP, ST_RECOVER: begin
          if (clean) begin
            if (qual_q == ((state_q == ST_STARTUP) ? START_LAST : REC_LAST)) begin
              state_q <= ST_RUN;
              qual_q  <= '0;
            end else begin
              qual_q <= qual_q + 1'b1;
            end
          end else if (bad) begin
            qual_q <= '0;
          end
        end
        ST_RUN: begin
          if (clean && can_load) begin
            out_data_q  <= samples;
            out_valid_q <= 1'b1;
          end else if (bad) begin
            state_q <= ST_RECOVER;
            qual_q  <= '0;
          end
        end
        ST_FAILED: begin
          out_valid_q <= 1'b0;
          if (clear_fail) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TRNG_CTRL_STATS_EN
  logic [CNT_W-1:0] alarm_q, alarm_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             alarm_evt, drop_evt;

  assign alarm_evt = !abort && (state_q == ST_RUN) && bad;
  assign drop_evt  = !abort && (state_q == ST_RUN) && clean && !can_load;

  // Both counters stick at all-ones rather than wrapping
  always_comb begin
    alarm_d = alarm_q;
    drop_d  = drop_q;
    if (alarm_evt && (alarm_q != '1)) alarm_d = alarm_q + 1'b1;
    if (drop_evt && (drop_q != '1))   drop_d  = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= '0;
      drop_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      drop_q  <= drop_d;
    end
  end

  assign alarm_cnt = alarm_q;
  assign drop_cnt  = drop_q;
`else
  assign alarm_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_trng_health_ctrl.sv
// Self-checking bench for trng_health_ctrl: hand tables, directed corner sequences and
// randomized traffic against a behavioural reference model.
module tb_trng_health_ctrl;
  localparam int NBITS = 32;
  localparam int SS    = 8;
  localparam int RS    = 4;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;
`ifdef TRNG_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear_fail = 1'b0;
  logic sample_valid = 1'b0, ht_error = 1'b0, ht_total_failure = 1'b0, out_ready = 1'b0;
  logic [NBITS-1:0] samples = '0;
  logic [NBITS-1:0] ht_samples, out_data;
  logic ht_enable, out_valid, fail;
  logic [2:0] state;
  logic [CW-1:0] alarm_cnt, drop_cnt;

  always #5 clk = ~clk;

  trng_health_ctrl #(
    .NBITS(NBITS), .STARTUP_SAMPLES(SS), .RECOVER_SAMPLES(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear_fail(clear_fail),
    .samples(samples), .sample_valid(sample_valid), .ht_samples(ht_samples),
    .ht_enable(ht_enable), .ht_error(ht_error), .ht_total_failure(ht_total_failure),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .state(state), .fail(fail), .alarm_cnt(alarm_cnt), .drop_cnt(drop_cnt)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: phase number, clean-run length, buffered word and event tallies
  int mState, mCnt, mAlarm, mDrop;
  bit mOv;
  logic [NBITS-1:0] mData;

  typedef struct {
    bit start, stop, valid, err, ready;
    logic [NBITS-1:0] data;
    int expState;
    bit expValid;
    logic [NBITS-1:0] expData;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int satInc(input int x);
    return (x >= SAT) ? SAT : x + 1;
  endfunction

  function automatic void modelReset();
    mState = 0; mCnt = 0; mAlarm = 0; mDrop = 0; mOv = 1'b0; mData = '0;
  endfunction

  function automatic void modelStep(input bit st, input bit sp, input bit cf, input bit v,
                                    input bit e, input bit tf, input bit rdy,
                                    input logic [NBITS-1:0] d);
    bit isClean = v && !e;
    bit isBad = v && e;
    bit busy = (mState >= 1) && (mState <= 3);
    int limit;
    if (busy && tf) begin
      mState = 4; mOv = 1'b0; mCnt = 0;
    end else if (busy && sp) begin
      mState = 0; mOv = 1'b0; mCnt = 0;
    end else begin
      case (mState)
        0: if (st) begin mState = 1; mCnt = 0; end
        1, 3: begin
          limit = (mState == 1) ? SS : RS;
          if (isClean) begin
            mCnt++;
            if (mCnt == limit) begin mState = 2; mCnt = 0; end
          end else if (isBad) mCnt = 0;
          if (mOv && rdy) mOv = 1'b0;
        end
        2: begin
          if (isClean && (!mOv || rdy)) begin
            mData = d; mOv = 1'b1;
          end else begin
            if (mOv && rdy) mOv = 1'b0;
            if (isClean) mDrop = satInc(mDrop);
            if (isBad) begin mAlarm = satInc(mAlarm); mCnt = 0; mState = 3; end
          end
        end
        4: begin mOv = 1'b0; if (cf) mState = 0; end
        default: ;
      endcase
    end
  endfunction

  task automatic checkOutput();
    check("state", state, mState);
    check("out_valid", out_valid, mOv);
    check("out_data", out_data, mData);
    check("fail", fail, mState == 4);
    check("alarm_cnt", alarm_cnt, STATS ? mAlarm : 0);
    check("drop_cnt", drop_cnt, STATS ? mDrop : 0);
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit cf, input bit v,
                               input bit e, input bit tf, input bit rdy,
                               input logic [NBITS-1:0] d);
    start = st; stop = sp; clear_fail = cf; sample_valid = v; ht_error = e;
    ht_total_failure = tf; out_ready = rdy; samples = d;
    #1;
    check("ht_enable", ht_enable, v && (mState >= 1) && (mState <= 3));
    check("ht_samples", ht_samples, d);
    modelStep(st, sp, cf, v, e, tf, rdy, d);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic cleanSample(input logic [NBITS-1:0] d, input bit rdy);
    applyStimulus(0, 0, 0, 1, 0, 0, rdy, d);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    start = 0; stop = 0; clear_fail = 0; sample_valid = 0; ht_error = 0;
    ht_total_failure = 0; out_ready = 0; samples = '0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic qualify();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < SS; i++) cleanSample($urandom, 0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      vecs[i] = '{start: 0, stop: 0, valid: 1, err: 0, ready: 0, data: 32'(i),
                  expState: 1, expValid: 0, expData: '0};
    end
    vecs[0].valid = 0; vecs[0].start = 1;
    vecs[8].expState = 2;
    vecs[9] = '{0, 0, 1, 0, 1, 32'hA5A5A5A5, 2, 1, 32'hA5A5A5A5};
    vecs[10] = '{0, 0, 1, 1, 0, 32'h0BADBEEF, 3, 1, 32'hA5A5A5A5};
    vecs[11] = '{0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0};

    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, 0, vecs[i].valid, vecs[i].err, 0,
                    vecs[i].ready, vecs[i].data);
      check("vec_state", state, vecs[i].expState);
      check("vec_valid", out_valid, vecs[i].expValid);
      if (vecs[i].expValid) check("vec_data", out_data, vecs[i].expData);
    end

    // Startup restart: error on 5th sample, then 8 more clean ones needed
    resetDut();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cleanSample($urandom, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, $urandom);
    for (int i = 0; i < SS - 1; i++) cleanSample($urandom, 0);
    check("restart_not_yet", state, 1);
    cleanSample($urandom, 0);
    check("restart_run", state, 2);

    // Alarm then recovery with one interrupted run
    cleanSample(32'h1111_1111, 1);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'hDEAD0000);
    check("alarm_state", state, 3);
    check("alarm_cnt_one", alarm_cnt, STATS ? 1 : 0);
    cleanSample(32'hDEAD0001, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'hDEAD0002);
    for (int i = 0; i < RS - 1; i++) cleanSample(32'hDEAD0010 + 32'(i), 0);
    check("recover_not_yet", state, 3);
    cleanSample(32'hDEAD0020, 0);
    check("recover_run", state, 2);
    check("recover_held_data", out_data, 32'h1111_1111);
    check("recover_held_valid", out_valid, 1);

    // Backpressure: first word held, following two dropped, then replace on transfer
    applyStimulus(0, 0, 0, 0, 0, 0, 1, '0);
    cleanSample(32'hB1, 0);
    cleanSample(32'hB2, 0);
    cleanSample(32'hB3, 0);
    check("bp_held", out_data, 32'hB1);
    check("bp_drops", drop_cnt, STATS ? 2 : 0);
    cleanSample(32'hB4, 1);
    check("bp_reload", out_data, 32'hB4);
    check("bp_reload_valid", out_valid, 1);

    // Total failure with a pending word, latch, clear, and re-failure from STARTUP
    applyStimulus(0, 0, 0, 0, 0, 1, 0, '0);
    check("tf_state", state, 4);
    check("tf_fail", fail, 1);
    check("tf_flush", out_valid, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, $urandom);
    check("tf_start_ignored", state, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);
    check("tf_cleared", state, 0);
    check("tf_fail_low", fail, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, '0);
    check("tf_idle_ignores", state, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, '0);
    check("tf_refail", state, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);

    // Stop during RECOVER clears the qualification count
    qualify();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, $urandom);
    cleanSample($urandom, 0);
    cleanSample($urandom, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    check("stop_idle", state, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < SS - 1; i++) cleanSample($urandom, 0);
    check("stop_count_cleared", state, 1);
    cleanSample($urandom, 0);
    check("stop_requalified", state, 2);

    // Asynchronous reset mid-RUN with a pending word
    cleanSample(32'hCAFEF00D, 0);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    check("async_state", state, 0);
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_alarm", alarm_cnt, 0);
    check("async_drop", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(7) == 0, $urandom_range(63) == 0, $urandom_range(7) == 0,
                    $urandom_range(3) != 0, $urandom_range(11) == 0, $urandom_range(63) == 0,
                    $urandom_range(1) == 1, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
